// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch (0) and data (1)
// All outputs are registered; the FSM is IDLE -> BUSY -> RESP -> IDLE with an abort timeout in BUSY.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              done0_o,
    output logic              done1_o,
    output logic              err0_o,
    output logic              err1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              sel_o,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              err0_q, err0_d;
    logic              err1_q, err1_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic any_req;
    logic grant_port;
    logic ack_hit;
    logic timeout_hit;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        any_req     = req0_i | req1_i;
        grant_port  = (req0_i & req1_i) ? ~last_q : req1_i;
        ack_hit     = (state_q == ST_BUSY) & mem_ack_i;
        timeout_hit = (state_q == ST_BUSY) & ~mem_ack_i & (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            busy_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req) state_d = ST_BUSY;
            ST_BUSY: if (ack_hit || timeout_hit) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        last_d      = last_q;
        sel_d       = sel_q;
        busy_d      = (state_d != ST_IDLE);
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    last_d      = grant_port;
                    sel_d       = grant_port;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = grant_port ? we1_i : we0_i;
                    mem_addr_d  = grant_port ? addr1_i : addr0_i;
                    mem_wdata_d = grant_port ? wdata1_i : wdata0_i;
                end
            end
            ST_BUSY: begin
                if (ack_hit) begin
                    rdata_d   = mem_rdata_i;
                    mem_req_d = 1'b0;
                    done0_d   = ~sel_q;
                    done1_d   = sel_q;
                end else if (timeout_hit) begin
                    rdata_d   = '0;
                    mem_req_d = 1'b0;
                    err0_d    = ~sel_q;
                    err1_d    = sel_q;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign done0_o     = done0_q;
    assign done1_o     = done1_q;
    assign err0_o      = err0_q;
    assign err1_o      = err1_q;
    assign rdata_o     = rdata_q;
    assign sel_o       = sel_q;
    assign busy_o      = busy_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        done0, done1, err0, err1;
    logic [31:0] rdata;
    logic        sel, busy;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
        .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
        .done0_o(done0), .done1_o(done1), .err0_o(err0), .err1_o(err1),
        .rdata_o(rdata), .sel_o(sel), .busy_o(busy),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req0 = 0; we0 = 0; req1 = 0; we1 = 0;
        addr0 = 0; wdata0 = 0; addr1 = 0; wdata1 = 0;
        mem_ack = 0; mem_rdata = 0;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_sel", sel, 0);
        chk("rst_done0", done0, 0);
        chk("rst_rdata", rdata, 0);

        // Port 0 read, ack two cycles after mem_req_o rises
        req0 = 1; addr0 = 32'h10;
        step();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_sel", sel, 0);
        chk("t1_busy", busy, 1);
        step();
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        step();
        chk("t1_done0", done0, 1);
        chk("t1_done1", done1, 0);
        chk("t1_rdata", rdata, 32'hDEADBEEF);
        chk("t1_mem_req_drop", mem_req, 0);
        mem_ack = 0; req0 = 0;
        step();
        chk("t1_done0_pulse", done0, 0);
        chk("t1_idle", busy, 0);

        // Both ports requesting continuously, immediate acks
        rst = 1; step(); rst = 0;
        req0 = 1; req1 = 1; addr0 = 32'h100; addr1 = 32'h200;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_sel", sel, i % 2);
            chk("rr_addr", mem_addr, (i % 2) ? 32'h200 : 32'h100);
            mem_ack = 1; mem_rdata = 32'hA0 + i;
            step();
            chk("rr_done0", done0, (i % 2) == 0);
            chk("rr_done1", done1, (i % 2) == 1);
            chk("rr_rdata", rdata, 32'hA0 + i);
            mem_ack = 0;
            step();
        end
        req0 = 0; req1 = 0;
        step();

        // Port 1 write with address/data changed mid-BUSY
        req1 = 1; we1 = 1; addr1 = 32'h40; wdata1 = 32'h1234;
        step();
        addr1 = 32'h80; wdata1 = 32'h9999; we1 = 0;
        step();
        chk("t3_sel", sel, 1);
        chk("t3_addr", mem_addr, 32'h40);
        chk("t3_we", mem_we, 1);
        chk("t3_wdata", mem_wdata, 32'h1234);
        mem_ack = 1; mem_rdata = 32'h55;
        step();
        chk("t3_done1", done1, 1);
        chk("t3_done0", done0, 0);
        mem_ack = 0; req1 = 0;
        step();

        // Timeout with no ack
        req0 = 1; we0 = 0; addr0 = 32'h20;
        step();
        for (int i = 0; i < 14; i++) begin
            step();
            chk("to_mem_req_held", mem_req, 1);
        end
        step();
        chk("to_err0", err0, 1);
        chk("to_done0", done0, 0);
        chk("to_mem_req", mem_req, 0);
        chk("to_rdata", rdata, 0);
        req0 = 0;
        step();
        chk("to_err0_pulse", err0, 0);
        chk("to_idle", busy, 0);

        // Ack on the exact timeout edge wins
        req0 = 1;
        step();
        for (int i = 0; i < 14; i++) step();
        mem_ack = 1; mem_rdata = 32'hCAFE;
        step();
        chk("ate_done0", done0, 1);
        chk("ate_err0", err0, 0);
        chk("ate_rdata", rdata, 32'hCAFE);
        mem_ack = 0; req0 = 0;
        step();
        mem_ack = 1; mem_rdata = 32'h1111;
        step();
        chk("stray_busy", busy, 0);
        chk("stray_mem_req", mem_req, 0);
        chk("stray_rdata", rdata, 32'hCAFE);
        chk("stray_done0", done0, 0);
        mem_ack = 0;

        // Reset mid-BUSY
        req1 = 1; addr1 = 32'h300;
        step();
        chk("mr_busy_before", busy, 1);
        rst = 1; req1 = 0;
        step();
        rst = 0;
        chk("mr_busy", busy, 0);
        chk("mr_mem_req", mem_req, 0);
        chk("mr_sel", sel, 0);
        chk("mr_addr", mem_addr, 0);
        chk("mr_rdata", rdata, 0);
        mem_ack = 1;
        step();
        chk("mr_no_done1", done1, 0);
        chk("mr_no_done0", done0, 0);
        mem_ack = 0;
        req0 = 1; req1 = 1; addr0 = 32'h500; addr1 = 32'h600;
        step();
        chk("mr_tie_sel", sel, 0);
        chk("mr_tie_addr", mem_addr, 32'h500);
        req0 = 0; req1 = 0;
        step(); step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between two requesters: port 0 is instruction fetch, port 1 is data access.
- Arbitrates round-robin on simultaneous requests.
- Latches the winning request, drives the shared memory port, and returns read data with a one-cycle done pulse to the owner.
- Drives the select of the downstream 2-to-1 data multiplexer; sits between the CPU stages and the memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 15, max cycles in BUSY without mem_ack_i before abort (must be >=1).
- CNT_W, 4, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  synchronous reset, active-high
- req0_i  input  1  port 0 request, held until done0_o/err0_o
- we0_i  input  1  port 0 write enable
- addr0_i  input  ADDR_W  port 0 address
- wdata0_i  input  DATA_W  port 0 write data
- req1_i, we1_i, addr1_i, wdata1_i  input  1/1/ADDR_W/DATA_W  port 1, same meaning as port 0
- done0_o, done1_o  output  1  one-cycle completion pulse per port
- err0_o, err1_o  output  1  one-cycle timeout-abort pulse per port
- rdata_o  output  DATA_W  registered read data, valid when done*_o high
- sel_o  output  1  current owner (0/1), drives the external MUX select
- busy_o  output  1  high while not IDLE
- mem_req_o  output  1  memory request, held for the whole transaction
- mem_we_o  output  1  memory write enable
- mem_addr_o  output  ADDR_W  memory address
- mem_wdata_o  output  DATA_W  memory write data
- mem_ack_i  input  1  memory completion, one cycle
- mem_rdata_i  input  DATA_W  memory read data, valid with mem_ack_i

Behaviour:
- All state and outputs are registered. Reset (synchronous, any state including mid-transaction):
  - state=IDLE; all outputs 0.
  - last_grant=1, so port 0 wins the first tie.
  - Counter cleared; any in-flight transaction is dropped silently with no done/err.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If neither req is high, stay.
  - If exactly one is high, grant it.
  - If both are high, grant the port != last_grant.
  - On a grant at edge N: state=BUSY, owner/sel_o/last_grant=granted port, latch we/addr/wdata into mem_*_o, mem_req_o=1, busy_o=1, counter=0. mem_req_o is therefore first high in cycle N+1.
- BUSY:
  - mem_*_o are held stable; requester inputs are ignored, including a req drop or a change of addr/wdata.
  - If mem_ack_i=1: rdata_o<=mem_rdata_i (for writes too), mem_req_o<=0, state=RESP, owner's done pulses next cycle.
  - Else if counter==TIMEOUT-1: mem_req_o<=0, state=RESP, owner's err pulses next cycle, rdata_o<=0.
  - Else counter+1.
  - mem_ack_i on the same edge as the timeout limit counts as success (ack wins).
- RESP:
  - Exactly one of done/err is high for the owner, for one cycle.
  - Requests are ignored in this state; next state is IDLE.
  - Latency: ack sampled at edge M gives done at M+1 and IDLE at M+2.
  - Minimum transaction is 3 cycles from request sampled to IDLE.
- Requester contract:
  - Deassert req on the edge after seeing done/err, or keep it high only for a new request.
  - A req still high in IDLE is treated as a new request.
- mem_ack_i outside BUSY is ignored.
- sel_o holds the last owner in IDLE/RESP and is cleared only by reset.
- busy_o=1 in BUSY and RESP.
- The counter saturates and does not wrap.

Test Plan:
- Reset, then req0=1, we0=0, addr0=0x10, memory acks 2 cycles after mem_req_o with 0xDEADBEEF -> mem_addr_o=0x10, sel_o=0, done0_o one pulse, rdata_o=0xDEADBEEF, IDLE two cycles after the ack.
- req0 and req1 held high continuously with immediate acks -> grants alternate 0,1,0,1 (first grant port 0); sel_o toggles; no done1 before done0.
- Port 1 write (we1=1, addr1=0x40, wdata1=0x1234) where addr1 changes to 0x80 mid-BUSY -> mem_addr_o stays 0x40, mem_we_o=1, mem_wdata_o=0x1234, done1_o pulse.
- No ack for TIMEOUT=15 cycles -> mem_req_o drops after 15 BUSY cycles, err0_o pulses once, done0_o stays 0, rdata_o=0.
- mem_ack_i on the exact timeout edge -> done pulse and no err. Stray mem_ack_i in IDLE -> no output change.
- rst_i asserted mid-BUSY -> next cycle all outputs 0, state IDLE. A later ack produces no done. The next tie grants port 0.
